// File: rtl/wb_led_seq_if.sv
// Wishbone classic slave bus bundle for the LED pattern sequencer.
interface wb_led_seq_if;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;

    modport slave (
        input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_ack_o, wb_dat_o
    );

    modport master (
        output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_ack_o, wb_dat_o
    );
endinterface

// File: rtl/wb_led_seq.sv
// LED pattern sequencer: plays words from a pattern RAM onto led_o, one word per
// HOLD period, configured and loaded through a Wishbone register map.
//
// state   | meaning
// S_IDLE  | stopped; Wishbone owns the RAM read port
// S_FETCH | RAM read issued at CUR_ADDR
// S_LATCH | RAM word loaded onto led_o, hold counter armed
// S_HOLD  | counting down, then advance / wrap / finish
module wb_led_seq #(
    parameter int DW = 24,
    parameter int AW = 6,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    wb_led_seq_if.slave   wb,
    output logic [DW-1:0] led_o,
    output logic          done_o,
    output logic          irq_o
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LATCH, S_HOLD} state_t;

    state_t        state_q, state_d;
    logic          loop_q, loop_d, irq_en_q, irq_en_d;
    logic          done_q, done_d, irq_q, irq_d;
    logic [AW-1:0] start_q, start_d, end_q, end_d;
    logic [AW-1:0] ptr_q, ptr_d, cur_q, cur_d;
    logic [CW-1:0] hold_q, hold_d, cnt_q, cnt_d;
    logic [DW-1:0] led_q, led_d;
    logic          ack_q, ack_d, rd_pend_q, rd_pend_d;
    logic [31:0]   dat_q, dat_d;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_rd_q;
    logic [AW-1:0] ram_raddr;
    logic          ram_we;

    logic          req, mapped, wr, busy, start_cmd, stop_cmd;
    logic [2:0]    reg_sel;
    logic [31:0]   rd_data;
    logic          unused_sel;

    assign unused_sel = ^wb.wb_sel_i;

    assign busy      = (state_q != S_IDLE);
    // ack_q/rd_pend_q gate the request so each access acks exactly once
    assign req       = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q & ~rd_pend_q;
    assign mapped    = (wb.wb_adr_i[31:5] == '0) && (wb.wb_adr_i[1:0] == 2'b00);
    assign reg_sel   = wb.wb_adr_i[4:2];
    assign wr        = req & wb.wb_we_i & mapped;
    assign stop_cmd  = wr && (reg_sel == 3'd0) && wb.wb_dat_i[3];
    assign start_cmd = wr && (reg_sel == 3'd0) && wb.wb_dat_i[0] && !wb.wb_dat_i[3];
    assign ram_we    = wr && (reg_sel == 3'd6);
    assign ram_raddr = busy ? cur_q : ptr_q;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ptr_q] <= wb.wb_dat_i[DW-1:0];
        end
        ram_rd_q <= mem[ram_raddr];
    end

    always_comb begin
        rd_data = '0;
        if (mapped) begin
            case (reg_sel)
                3'd0:    rd_data[2:1]    = {irq_en_q, loop_q};
                3'd1:    rd_data[1:0]    = {busy, done_q};
                3'd2:    rd_data[AW-1:0] = start_q;
                3'd3:    rd_data[AW-1:0] = end_q;
                3'd4:    rd_data[CW-1:0] = hold_q;
                3'd5:    rd_data[AW-1:0] = ptr_q;
                3'd7:    rd_data[AW-1:0] = cur_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        loop_d    = loop_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        start_d   = start_q;
        end_d     = end_q;
        hold_d    = hold_q;
        ptr_d     = ptr_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        led_d     = led_q;
        ack_d     = 1'b0;
        rd_pend_d = 1'b0;
        dat_d     = dat_q;

        if (rd_pend_q) begin
            ack_d = 1'b1;
            dat_d = 32'(ram_rd_q);
        end else if (req) begin
            if (!wb.wb_we_i && mapped && (reg_sel == 3'd6) && !busy) begin
                rd_pend_d = 1'b1;
            end else begin
                ack_d = 1'b1;
                dat_d = wb.wb_we_i ? '0 : rd_data;
            end
        end

        if (wr) begin
            case (reg_sel)
                3'd0: begin
                    loop_d   = wb.wb_dat_i[1];
                    irq_en_d = wb.wb_dat_i[2];
                end
                3'd1:    if (wb.wb_dat_i[0]) done_d = 1'b0;
                3'd2:    start_d = wb.wb_dat_i[AW-1:0];
                3'd3:    end_d   = wb.wb_dat_i[AW-1:0];
                3'd4:    hold_d  = wb.wb_dat_i[CW-1:0];
                3'd5:    ptr_d   = wb.wb_dat_i[AW-1:0];
                3'd6:    ptr_d   = ptr_q + AW'(1);
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start_cmd) begin
                    cur_d   = start_q;
                    done_d  = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                led_d   = ram_rd_q;
                cnt_d   = (hold_q == '0) ? '0 : hold_q - CW'(1);
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (cur_q != end_q) begin
                    cur_d   = cur_q + AW'(1);
                    state_d = S_FETCH;
                end else if (loop_q) begin
                    cur_d   = start_q;
                    state_d = S_FETCH;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // STOP overrides whatever the sequencer decided, including a DONE set
        if (stop_cmd && busy) begin
            state_d = S_IDLE;
            done_d  = done_q;
        end

        irq_d = done_d & irq_en_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            loop_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            irq_q     <= 1'b0;
            start_q   <= '0;
            end_q     <= '0;
            hold_q    <= '0;
            ptr_q     <= '0;
            cur_q     <= '0;
            cnt_q     <= '0;
            led_q     <= '0;
            ack_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            loop_q    <= loop_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            irq_q     <= irq_d;
            start_q   <= start_d;
            end_q     <= end_d;
            hold_q    <= hold_d;
            ptr_q     <= ptr_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            led_q     <= led_d;
            ack_q     <= ack_d;
            rd_pend_q <= rd_pend_d;
            dat_q     <= dat_d;
        end
    end

    assign led_o       = led_q;
    assign done_o      = done_q;
    assign irq_o       = irq_q;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
endmodule
